pulse_gen_core: RTL and testbench

//  Synthesizable programmable pulse source driving the frequency-measurement stage downstream.

---
 rtl/pulse_gen_core.sv | 198 +++++++++++++++++++
 tb/tb_pulse_gen_core.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_core.sv
// pulse_gen_core: programmable pulse-train source.
// The period and high time are counted in clk_i cycles.
// New settings go into a one-deep shadow register. They become active only while idle or on
// the wrap cycle of a running period, so a period is never cut short or glitched.
// Optional feature: define PULSE_GEN_BURST_EN to enable burst mode. A burst runs a fixed number
// of periods and then stops. Without the macro the generator always runs continuously.
module pulse_gen_core #(
  parameter int PERIOD_WIDTH = 16,
  parameter int BURST_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [PERIOD_WIDTH-1:0] cfg_period_i,
  input  logic [PERIOD_WIDTH-1:0] cfg_high_i,
  input  logic [BURST_WIDTH-1:0]  cfg_burst_i,
  input  logic                    enable_i,
  output logic                    pulse_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [PERIOD_WIDTH-1:0] MinPeriod = PERIOD_WIDTH'(2);
  localparam logic [PERIOD_WIDTH-1:0] One       = PERIOD_WIDTH'(1);

  state_e                  state_q;
  logic [PERIOD_WIDTH-1:0] cnt_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] high_q;
  logic                    pulse_q;
  logic                    done_q;

  logic                    shadowFull_q;
  logic                    shadowFull_d;
  logic [PERIOD_WIDTH-1:0] shadowPeriod_q;
  logic [PERIOD_WIDTH-1:0] shadowHigh_q;

  logic                    accept;
  logic                    drain;
  logic                    wrap;
  logic                    startRun;
  logic                    stopRun;
  logic [PERIOD_WIDTH-1:0] loadPeriod;
  logic [PERIOD_WIDTH-1:0] loadHigh;
  logic [PERIOD_WIDTH-1:0] effHigh;

`ifdef PULSE_GEN_BURST_EN
  logic [BURST_WIDTH-1:0]  shadowBurst_q;
  logic [BURST_WIDTH-1:0]  burst_q;
  logic [BURST_WIDTH-1:0]  burstCnt_q;
  logic [BURST_WIDTH-1:0]  effBurst;
  logic                    burstDone;
  logic                    block_q;
`else
  logic                    unusedBurst;
  assign unusedBurst = ^cfg_burst_i;
`endif

  // Clamp the shadow values as they would land in the active registers; pick the config the next period uses
  always_comb begin
    loadPeriod = (shadowPeriod_q < MinPeriod) ? MinPeriod : shadowPeriod_q;
    loadHigh   = (shadowHigh_q >= loadPeriod) ? (loadPeriod - One) : shadowHigh_q;
    effHigh    = shadowFull_q ? loadHigh : high_q;
  end

  assign wrap   = (state_q == LOW) && (cnt_q == (period_q - One));
  assign drain  = shadowFull_q && ((state_q == IDLE) || wrap);
  assign accept = cfg_valid_i && !shadowFull_q;

`ifdef PULSE_GEN_BURST_EN
  assign effBurst  = shadowFull_q ? shadowBurst_q : burst_q;
  assign burstDone = (effBurst != '0) && (burstCnt_q >= (effBurst - BURST_WIDTH'(1)));
  assign stopRun   = !enable_i || burstDone;
  assign startRun  = enable_i && !block_q;
`else
  assign stopRun   = !enable_i;
  assign startRun  = enable_i;
`endif

  // Shadow occupancy: an accepted beat fills it, a transfer to the active set empties it
  always_comb begin
    shadowFull_d = shadowFull_q;
    if (accept) begin
      shadowFull_d = 1'b1;
    end else if (drain) begin
      shadowFull_d = 1'b0;
    end
  end

  // Shadow register capture on valid & ready
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      shadowFull_q   <= 1'b0;
      shadowPeriod_q <= '0;
      shadowHigh_q   <= '0;
`ifdef PULSE_GEN_BURST_EN
      shadowBurst_q  <= '0;
`endif
    end else begin
      shadowFull_q <= shadowFull_d;
      if (accept) begin
        shadowPeriod_q <= cfg_period_i;
        shadowHigh_q   <= cfg_high_i;
`ifdef PULSE_GEN_BURST_EN
        shadowBurst_q  <= cfg_burst_i;
`endif
      end
    end
  end

`ifdef PULSE_GEN_BURST_EN
  // Burst bookkeeping: periods completed in this run and the re-arm lockout after a finished burst
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      burst_q    <= '0;
      burstCnt_q <= '0;
      block_q    <= 1'b0;
    end else begin
      if (drain) begin
        burst_q <= shadowBurst_q;
      end
      if ((state_q == IDLE) && startRun) begin
        burstCnt_q <= '0;
      end else if (wrap && !stopRun && (burstCnt_q != '1)) begin
        burstCnt_q <= burstCnt_q + BURST_WIDTH'(1);
      end
      if (wrap && burstDone && enable_i) begin
        block_q <= 1'b1;
      end else if ((state_q == IDLE) && !enable_i) begin
        block_q <= 1'b0;
      end
    end
  end
`endif

  // Main FSM: the period counter, the active config load and the registered pulse/done outputs
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= MinPeriod;
      high_q   <= One;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pulse_q <= (state_q == HIGH);
      done_q  <= 1'b0;
      if (drain) begin
        period_q <= loadPeriod;
        high_q   <= loadHigh;
      end
      case (state_q)
        IDLE: begin
          if (startRun) begin
            cnt_q   <= '0;
            state_q <= (effHigh == '0) ? LOW : HIGH;
          end
        end
        HIGH: begin
          cnt_q <= cnt_q + One;
          if (cnt_q == (high_q - One)) begin
            state_q <= LOW;
          end
        end
        LOW: begin
          if (wrap) begin
            cnt_q <= '0;
            if (stopRun) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= (effHigh == '0) ? LOW : HIGH;
            end
          end else begin
            cnt_q <= cnt_q + One;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pulse_o     = pulse_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);
  assign cfg_ready_o = !shadowFull_q;

endmodule

// File: tb/tb_pulse_gen_core.sv
// Testbench for pulse_gen_core.
// A behavioural model tracks the position inside the period and the pending configuration.
// Scenario tasks and a randomized run compare the DUT outputs against that model.
module tb_pulse_gen_core;

  localparam int PW = 16;
  localparam int BW = 8;
`ifdef PULSE_GEN_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          arstn_i = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [PW-1:0] cfg_period_i = '0;
  logic [PW-1:0] cfg_high_i = '0;
  logic [BW-1:0] cfg_burst_i = '0;
  logic          enable_i = 1'b0;
  logic          pulse_o;
  logic          busy_o;
  logic          done_o;

  int testCount = 0;
  int failCount = 0;

  // Reference model state: run flag, position in period, active and pending config
  bit mRunning, mPulse, mDone, mBlocked, mShFull;
  int mPos, mPeriod, mHigh, mBurst, mPeriodsDone, mShP, mShH, mShB;

  pulse_gen_core #(.PERIOD_WIDTH(PW), .BURST_WIDTH(BW)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_period_i(cfg_period_i), .cfg_high_i(cfg_high_i), .cfg_burst_i(cfg_burst_i),
    .enable_i(enable_i), .pulse_o(pulse_o), .busy_o(busy_o), .done_o(done_o)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // Hard stop in case a scenario never returns
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    mRunning = 0; mPulse = 0; mDone = 0; mBlocked = 0; mShFull = 0;
    mPos = 0; mPeriod = 2; mHigh = 1; mBurst = 0; mPeriodsDone = 0;
    mShP = 0; mShH = 0; mShB = 0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs seen at that edge
  function automatic void modelStep();
    bit accept, wrapNow, load, pulseNext;
    accept    = cfg_valid_i && !mShFull;
    pulseNext = mRunning && (mPos < mHigh);
    wrapNow   = mRunning && (mPos == mPeriod - 1);
    load      = mShFull && (!mRunning || wrapNow);
    mDone     = 0;
    if (load) begin
      mPeriod = (mShP < 2) ? 2 : mShP;
      mHigh   = (mShH >= mPeriod) ? mPeriod - 1 : mShH;
      mBurst  = BurstEn ? mShB : 0;
      mShFull = 0;
    end
    if (!mRunning) begin
      if (enable_i && !mBlocked) begin
        mRunning = 1; mPos = 0; mPeriodsDone = 0;
      end
      if (!enable_i) mBlocked = 0;
    end else if (wrapNow) begin
      mPeriodsDone++;
      if (!enable_i || (mBurst != 0 && mPeriodsDone >= mBurst)) begin
        mRunning = 0; mDone = 1; mBlocked = enable_i;
      end else begin
        mPos = 0;
      end
    end else begin
      mPos++;
    end
    if (accept) begin
      mShFull = 1; mShP = int'(cfg_period_i); mShH = int'(cfg_high_i); mShB = int'(cfg_burst_i);
    end
    mPulse = pulseNext;
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    modelStep();
    @(negedge clk_i);
  endtask

  task automatic doReset();
    arstn_i = 1'b0; cfg_valid_i = 1'b0; enable_i = 1'b0;
    modelReset();
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
  endtask

  task automatic writeCfg(input int p, input int h, input int b);
    cfg_valid_i = 1'b1; cfg_period_i = PW'(p); cfg_high_i = PW'(h); cfg_burst_i = BW'(b);
    cycle();
    cfg_valid_i = 1'b0;
  endtask

  // Reset values and the default 2/1 configuration
  task automatic test_reset();
    doReset();
    if ({pulse_o, busy_o, done_o, cfg_ready_o} !== 4'b0001) begin
      failCount++;
      $display("[TB] FAIL reset_values: got %b want 0001 (pulse,busy,done,ready)", {pulse_o, busy_o, done_o, cfg_ready_o});
    end
    testCount++;
    enable_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) enable_i = 1'b0;
      cycle();
      if ({pulse_o, busy_o, done_o, cfg_ready_o} !== {mPulse, mRunning, mDone, !mShFull}) begin
        failCount++;
        $display("[TB] FAIL reset_default_cfg cycle %0d: got %b want %b", i, {pulse_o, busy_o, done_o, cfg_ready_o}, {mPulse, mRunning, mDone, !mShFull});
      end
      testCount++;
    end
  endtask

  // 100/30 continuous run: latency, duty and rise count
  task automatic test_basic();
    int highs, rises;
    bit prev;
    doReset();
    writeCfg(100, 30, 0);
    cycle();
    enable_i = 1'b1;
    cycle();
    if (pulse_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL basic_latency0: got %b want 0", pulse_o);
    end
    testCount++;
    highs = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (i == 0) begin
        if (pulse_o !== 1'b1) begin
          failCount++; $display("[TB] FAIL basic_first_rise: got %b want 1", pulse_o);
        end
        testCount++;
      end
      if ({pulse_o, busy_o, done_o, cfg_ready_o} !== {mPulse, mRunning, mDone, !mShFull}) begin
        failCount++;
        $display("[TB] FAIL basic_model cycle %0d: got %b want %b", i, {pulse_o, busy_o, done_o, cfg_ready_o}, {mPulse, mRunning, mDone, !mShFull});
      end
      testCount++;
      if (pulse_o === 1'b1) highs++;
      if (pulse_o === 1'b1 && !prev) rises++;
      prev = pulse_o;
    end
    if (highs != 60 || rises != 2) begin
      failCount++; $display("[TB] FAIL basic_duty: got highs=%0d rises=%0d want highs=60 rises=2", highs, rises);
    end
    testCount++;
  endtask

  // Mid-period config write is deferred to the next period; a second write is refused
  task automatic test_shadow();
    int highsOld, highsNew;
    doReset();
    writeCfg(100, 30, 0);
    cycle();
    enable_i = 1'b1;
    cycle();
    repeat (10) cycle();
    writeCfg(50, 25, 0);
    if (cfg_ready_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL shadow_ready_after_write: got %b want 0", cfg_ready_o);
    end
    testCount++;
    writeCfg(77, 7, 0);
    if (cfg_ready_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL shadow_second_write: got ready=%b want 0", cfg_ready_o);
    end
    testCount++;
    highsOld = 0;
    for (int i = 0; i < 88; i++) begin
      cycle();
      if ({pulse_o, busy_o, done_o, cfg_ready_o} !== {mPulse, mRunning, mDone, !mShFull}) begin
        failCount++;
        $display("[TB] FAIL shadow_model cycle %0d: got %b want %b", i, {pulse_o, busy_o, done_o, cfg_ready_o}, {mPulse, mRunning, mDone, !mShFull});
      end
      testCount++;
      if (pulse_o === 1'b1) highsOld++;
    end
    if (highsOld != 18 || cfg_ready_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL shadow_old_period: got highs=%0d ready=%b want highs=18 ready=1", highsOld, cfg_ready_o);
    end
    testCount++;
    highsNew = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (pulse_o === 1'b1) highsNew++;
    end
    if (highsNew != 25) begin
      failCount++; $display("[TB] FAIL shadow_new_period: got highs=%0d want 25", highsNew);
    end
    testCount++;
  endtask

  // Clamping: period 0 / high 5 becomes 2/1; high 0 keeps the output low while running
  task automatic test_clamp();
    int rises, highs, busies;
    bit prev;
    doReset();
    writeCfg(0, 5, 0);
    cycle();
    enable_i = 1'b1;
    cycle();
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if ({pulse_o, busy_o, done_o, cfg_ready_o} !== {mPulse, mRunning, mDone, !mShFull}) begin
        failCount++;
        $display("[TB] FAIL clamp_model cycle %0d: got %b want %b", i, {pulse_o, busy_o, done_o, cfg_ready_o}, {mPulse, mRunning, mDone, !mShFull});
      end
      testCount++;
      if (pulse_o === 1'b1 && !prev) rises++;
      prev = pulse_o;
    end
    if (rises != 5) begin
      failCount++; $display("[TB] FAIL clamp_toggle: got rises=%0d want 5", rises);
    end
    testCount++;
    enable_i = 1'b0;
    for (int i = 0; i < 8 && busy_o !== 1'b0; i++) cycle();
    if (busy_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL clamp_stop_timeout: got busy=%b want 0", busy_o);
    end
    testCount++;
    writeCfg(20, 0, 0);
    cycle();
    enable_i = 1'b1;
    cycle();
    highs = 0; busies = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (pulse_o === 1'b1) highs++;
      if (busy_o === 1'b1) busies++;
    end
    if (highs != 0 || busies != 40) begin
      failCount++; $display("[TB] FAIL clamp_high_zero: got highs=%0d busy=%0d want highs=0 busy=40", highs, busies);
    end
    testCount++;
  endtask

  // Dropping enable mid-period lets the period finish, then done_o fires once
  task automatic test_stop();
    int doneAt, doneCount, rises;
    bit prev;
    doReset();
    writeCfg(100, 30, 0);
    cycle();
    enable_i = 1'b1;
    cycle();
    repeat (40) cycle();
    enable_i = 1'b0;
    doneAt = 0; doneCount = 0; rises = 0; prev = pulse_o;
    for (int i = 1; i <= 70; i++) begin
      cycle();
      if ({pulse_o, busy_o, done_o, cfg_ready_o} !== {mPulse, mRunning, mDone, !mShFull}) begin
        failCount++;
        $display("[TB] FAIL stop_model cycle %0d: got %b want %b", i, {pulse_o, busy_o, done_o, cfg_ready_o}, {mPulse, mRunning, mDone, !mShFull});
      end
      testCount++;
      if (done_o === 1'b1) begin doneAt = i; doneCount++; end
      if (pulse_o === 1'b1 && !prev) rises++;
      prev = pulse_o;
    end
    if (doneAt != 60 || doneCount != 1 || rises != 0 || busy_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL stop_complete: got doneAt=%0d dones=%0d rises=%0d busy=%b want 60 1 0 0", doneAt, doneCount, rises, busy_o);
    end
    testCount++;
  endtask

  // Asynchronous reset asserted while the output is high
  task automatic test_async_reset();
    doReset();
    writeCfg(10, 5, 0);
    cycle();
    enable_i = 1'b1;
    for (int i = 0; i < 6 && pulse_o !== 1'b1; i++) cycle();
    if (pulse_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL async_no_high: got pulse=%b want 1", pulse_o);
    end
    testCount++;
    #2;
    arstn_i = 1'b0;
    #1;
    if ({pulse_o, busy_o, done_o, cfg_ready_o} !== 4'b0001) begin
      failCount++;
      $display("[TB] FAIL async_reset: got %b want 0001 (pulse,busy,done,ready)", {pulse_o, busy_o, done_o, cfg_ready_o});
    end
    testCount++;
    modelReset();
    enable_i = 1'b0;
    @(negedge clk_i);
    arstn_i = 1'b1;
    cycle();
    if ({pulse_o, busy_o, done_o, cfg_ready_o} !== {mPulse, mRunning, mDone, !mShFull}) begin
      failCount++;
      $display("[TB] FAIL async_after_release: got %b want %b", {pulse_o, busy_o, done_o, cfg_ready_o}, {mPulse, mRunning, mDone, !mShFull});
    end
    testCount++;
  endtask

`ifdef PULSE_GEN_BURST_EN
  // Burst of 3 periods with enable held, then re-arm through enable 1->0->1
  task automatic test_burst();
    int rises, dones;
    bit prev;
    doReset();
    writeCfg(10, 4, 3);
    cycle();
    enable_i = 1'b1;
    rises = 0; dones = 0; prev = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if ({pulse_o, busy_o, done_o, cfg_ready_o} !== {mPulse, mRunning, mDone, !mShFull}) begin
        failCount++;
        $display("[TB] FAIL burst_model cycle %0d: got %b want %b", i, {pulse_o, busy_o, done_o, cfg_ready_o}, {mPulse, mRunning, mDone, !mShFull});
      end
      testCount++;
      if (pulse_o === 1'b1 && !prev) rises++;
      if (done_o === 1'b1) dones++;
      prev = pulse_o;
    end
    if (rises != 3 || dones != 1 || busy_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL burst_count: got rises=%0d dones=%0d busy=%b want 3 1 0", rises, dones, busy_o);
    end
    testCount++;
    enable_i = 1'b0;
    cycle();
    enable_i = 1'b1;
    cycle();
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (pulse_o === 1'b1 && !prev) rises++;
      prev = pulse_o;
    end
    if (rises != 2) begin
      failCount++; $display("[TB] FAIL burst_rearm: got rises=%0d want 2", rises);
    end
    testCount++;
  endtask
`endif

  // Random enable toggling and config offers against the model
  task automatic test_random();
    doReset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) enable_i = ~enable_i;
      cfg_valid_i  = ($urandom_range(0, 5) == 0);
      cfg_period_i = PW'($urandom_range(0, 12));
      cfg_high_i   = PW'($urandom_range(0, 13));
      cfg_burst_i  = BW'($urandom_range(0, 4));
      cycle();
      if ({pulse_o, busy_o, done_o, cfg_ready_o} !== {mPulse, mRunning, mDone, !mShFull}) begin
        failCount++;
        $display("[TB] FAIL random_model cycle %0d: got %b want %b", i, {pulse_o, busy_o, done_o, cfg_ready_o}, {mPulse, mRunning, mDone, !mShFull});
      end
      testCount++;
    end
    cfg_valid_i = 1'b0;
    enable_i = 1'b0;
  endtask

  initial begin
    modelReset();
    test_reset();
    test_basic();
    test_shadow();
    test_clamp();
    test_stop();
    test_async_reset();
`ifdef PULSE_GEN_BURST_EN
    test_burst();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
